bike_motion_ctrl: RTL and testbench
===================================

Name: bike_motion_ctrl

Overview:
- Consumes the one-hot direction requests produced by the PS/2 keyboard-to-control stage for one player.
- Maintains that bike's heading, step timer and grid position, and reports crashes.
- Instantiated once per player. Feeds the trail/collision and VGA draw logic.
- Turn requests are registered and committed only at step boundaries. Instant 180-degree reversals are rejected.

Parameters:
- X_MAX, 159, last valid column (grid 0..X_MAX)
- Y_MAX, 119, last valid row (grid 0..Y_MAX)
- X_W, 8, x_pos width
- Y_W, 7, y_pos width
- X_START, 40, x reload value
- Y_START, 60, y reload value
- START_DIR, 2'd3, heading reload value (0=up, 1=left, 2=down, 3=right)
- TICK_DIV, 2500000, CLOCK_50 cycles per step (20 steps/s); legal range >= 2

Ports:
- CLOCK_50, in, 1, system clock
- resetn, in, 1, synchronous active-low reset
- dir_req, in, 4, one-hot request: 1000 up, 0100 left, 0010 down, 0001 right; 0000 = none
- game_en, in, 1, level; 1 = round running
- crash_in, in, 1, external collision flag (trail hit), sampled in RUN
- x_pos, out, X_W, current column
- y_pos, out, Y_W, current row (up = decreasing y)
- heading, out, 2, committed heading
- step_pulse, out, 1, one-cycle strobe; x_pos/y_pos are new in the same cycle
- alive, out, 1, high in IDLE and RUN, low in CRASHED
- state, out, 2, 0=IDLE, 1=RUN, 2=CRASHED

Behaviour:
- Reset (resetn=0 at clock edge) and IDLE entry perform the same reload:
  - state=IDLE; x_pos=X_START, y_pos=Y_START; heading=pending=START_DIR
  - tick counter=0; step_pulse=0; alive=1
- IDLE: hold the reload values. game_en=1 -> RUN next cycle; counter starts at 0.
- RUN:
  - The counter increments each cycle.
  - At counter==TICK_DIV-1, the next edge does all of the following: counter<=0, heading<=pending, position moves one cell in pending direction, step_pulse<=1 for that one cycle.
  - First step occurs TICK_DIV cycles after RUN entry.
- Turn filter, evaluated every cycle in RUN:
  - dir_req with exactly one bit set maps to code d (bit3->0, bit2->1, bit1->2, bit0->3).
  - If d != heading^2, pending<=d. Otherwise the request is ignored.
  - The opposite check is against the committed heading, not pending, so a left-then-reverse pair within one tick cannot reverse the bike.
  - 0000 or multi-bit dir_req: ignored; pending is kept.
  - Last valid request before the step wins.
- Edge rule (WRAP_EN undefined): if the step would move x below 0 or above X_MAX, or y below 0 or above Y_MAX:
  - state<=CRASHED, alive<=0
  - position unchanged, heading unchanged, step_pulse stays 0
- crash_in=1 in RUN -> CRASHED next edge, no move. This takes priority over a coincident step.
- CRASHED: position/heading frozen, dir_req ignored, counter held at 0. game_en=0 -> IDLE (reload).
- game_en=0 in RUN -> IDLE next edge (reload), taking priority over a step or crash_in in that cycle.
- resetn=0 has priority over everything, including mid-RUN and CRASHED.
- Arithmetic is unsigned, in X_W/Y_W bits. Boundary checks compare against 0/X_MAX/Y_MAX before the update; there is no reliance on overflow.

Optional Feature:
- Macro: BIKE_WRAP_EN
- Defined:
  - Edges wrap: x 0 moving left -> X_MAX; X_MAX moving right -> 0; same for y with Y_MAX.
  - Edge never causes CRASHED; step_pulse fires normally.
  - Only crash_in can kill the bike.
- Undefined: edge crash rule as in Behaviour.

Test Plan:
- TICK_DIV=4, defaults, reset, then game_en=1, no dir_req -> step_pulse at cycles 5, 9, 13 after game_en; x_pos 41, 42, 43; y_pos 60; heading 3.
- Heading 3: dir_req=1000 for 1 cycle, then 0100 for 1 cycle, within the same tick -> next step y_pos=59, x unchanged, heading=0 (0100 rejected as opposite of committed 3).
- Heading 3: dir_req=0100 (reverse) or 1010 (multi-bit) -> ignored; x continues incrementing; heading stays 3.
- X_START=158, heading right, TICK_DIV=4 -> one step to x=159, then next tick state=2, alive=0, x_pos stays 159, no step_pulse. With BIKE_WRAP_EN -> x=0, step_pulse=1, alive=1.
- crash_in=1 in the same cycle as counter==TICK_DIV-1 -> CRASHED, position unchanged. Then game_en=0 -> IDLE with x=40, y=60, heading=3.
- resetn=0 mid-RUN at x=45 -> next edge IDLE, x=40, step_pulse=0; staying IDLE while game_en=0.

Source files
------------

// File: rtl/bike_motion_ctrl.sv
// Per-player bike motion: heading, step timer, grid position and crash state.
// Define BIKE_WRAP_EN to make the grid edges wrap instead of killing the bike.
module bike_motion_ctrl #(
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned Y_MAX     = 119,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned X_START   = 40,
  parameter int unsigned Y_START   = 60,
  parameter logic [1:0]  START_DIR = 2'd3,
  parameter int unsigned TICK_DIV  = 2500000
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic [3:0]     dir_req,
  input  logic           game_en,
  input  logic           crash_in,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic [1:0]     heading,
  output logic           step_pulse,
  output logic           alive,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_CRASHED = 2'd2
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int unsigned    CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [X_W-1:0] X_LAST   = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(Y_MAX);
  localparam logic [X_W-1:0] X_RELOAD = X_W'(X_START);
  localparam logic [Y_W-1:0] Y_RELOAD = Y_W'(Y_START);

  state_t           state_q;
  logic [1:0]       pending;
  logic [CNT_W-1:0] tick_cnt;

  logic             req_valid;
  logic [1:0]       req_dir;
  logic             accept_turn;
  logic             at_edge;
  logic             edge_crash;
  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;

  assign state = state_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_UP;
    case (dir_req)
      4'b1000: req_dir = DIR_UP;
      4'b0100: req_dir = DIR_LEFT;
      4'b0010: req_dir = DIR_DOWN;
      4'b0001: req_dir = DIR_RIGHT;
      default: req_valid = 1'b0;
    endcase
  end

  // Reversal check is against the committed heading, not pending.
  assign accept_turn = req_valid && (req_dir != (heading ^ 2'd2));

  // Next cell in the pending direction; edges are detected before any arithmetic.
  always_comb begin
    at_edge = 1'b0;
    x_next  = x_pos;
    y_next  = y_pos;
    case (pending)
      DIR_UP: begin
        if (y_pos == '0) begin
          at_edge = 1'b1;
          y_next  = Y_LAST;
        end else begin
          y_next  = y_pos - Y_W'(1);
        end
      end
      DIR_LEFT: begin
        if (x_pos == '0) begin
          at_edge = 1'b1;
          x_next  = X_LAST;
        end else begin
          x_next  = x_pos - X_W'(1);
        end
      end
      DIR_DOWN: begin
        if (y_pos == Y_LAST) begin
          at_edge = 1'b1;
          y_next  = '0;
        end else begin
          y_next  = y_pos + Y_W'(1);
        end
      end
      default: begin
        if (x_pos == X_LAST) begin
          at_edge = 1'b1;
          x_next  = '0;
        end else begin
          x_next  = x_pos + X_W'(1);
        end
      end
    endcase
  end

`ifdef BIKE_WRAP_EN
  assign edge_crash = 1'b0;
  logic unused_edge;
  assign unused_edge = at_edge;
`else
  assign edge_crash = at_edge;
`endif

  // NOTE: all state here is sequential, so it uses non-blocking assignments;
  // reset is synchronous and shares the IDLE reload path.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn || !game_en) begin
      state_q    <= S_IDLE;
      x_pos      <= X_RELOAD;
      y_pos      <= Y_RELOAD;
      heading    <= START_DIR;
      pending    <= START_DIR;
      tick_cnt   <= '0;
      step_pulse <= 1'b0;
      alive      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_RUN;
          tick_cnt   <= '0;
          step_pulse <= 1'b0;
        end

        S_RUN: begin
          if (crash_in) begin
            state_q    <= S_CRASHED;
            alive      <= 1'b0;
            step_pulse <= 1'b0;
            tick_cnt   <= '0;
          end else begin
            if (accept_turn) pending <= req_dir;
            if (tick_cnt == CNT_LAST) begin
              tick_cnt <= '0;
              if (edge_crash) begin
                state_q    <= S_CRASHED;
                alive      <= 1'b0;
                step_pulse <= 1'b0;
              end else begin
                x_pos      <= x_next;
                y_pos      <= y_next;
                heading    <= pending;
                step_pulse <= 1'b1;
              end
            end else begin
              tick_cnt   <= tick_cnt + CNT_W'(1);
              step_pulse <= 1'b0;
            end
          end
        end

        S_CRASHED: begin
          tick_cnt   <= '0;
          step_pulse <= 1'b0;
          alive      <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          x_pos      <= X_RELOAD;
          y_pos      <= Y_RELOAD;
          heading    <= START_DIR;
          pending    <= START_DIR;
          tick_cnt   <= '0;
          step_pulse <= 1'b0;
          alive      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bike_motion_ctrl.sv
// Bench for bike_motion_ctrl: directed scenarios plus random traffic against a
// grid-level reference model; a second instance starts next to the right edge.
module tb_bike_motion_ctrl;

  localparam int TICK = 4;
  localparam int XM   = 159;
  localparam int YM   = 119;

`ifdef BIKE_WRAP_EN
  localparam int E_X = 0,   E_STEP = 1, E_ALIVE = 1, E_STATE = 1;
  localparam int UP_STATE = 1;
`else
  localparam int E_X = 159, E_STEP = 0, E_ALIVE = 0, E_STATE = 2;
  localparam int UP_STATE = 2;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       resetn, game_en, crash_in;
  logic [3:0] dir_req;

  logic [7:0] x_pos, e_x;
  logic [6:0] y_pos, e_y;
  logic [1:0] heading, state, e_heading, e_state;
  logic       step_pulse, alive, e_step, e_alive;

  always #10 CLOCK_50 = ~CLOCK_50;

  bike_motion_ctrl #(.TICK_DIV(TICK)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .dir_req(dir_req), .game_en(game_en),
    .crash_in(crash_in), .x_pos(x_pos), .y_pos(y_pos), .heading(heading),
    .step_pulse(step_pulse), .alive(alive), .state(state)
  );

  bike_motion_ctrl #(.TICK_DIV(TICK), .X_START(158)) dut_e (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .dir_req(dir_req), .game_en(game_en),
    .crash_in(crash_in), .x_pos(e_x), .y_pos(e_y), .heading(e_heading),
    .step_pulse(e_step), .alive(e_alive), .state(e_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: grid coordinates as plain integers, 0=IDLE 1=RUN 2=CRASHED.
  int m_state, m_x, m_y, m_head, m_pend, m_phase;
  int m_step;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int req_code(input logic [3:0] d);
    if ($countones(d) != 1) return -1;
    return 3 - $clog2(d);
  endfunction

  function automatic int dx(input int dir);
    return (dir == 1) ? -1 : (dir == 3) ? 1 : 0;
  endfunction

  function automatic int dy(input int dir);
    return (dir == 0) ? -1 : (dir == 2) ? 1 : 0;
  endfunction

  task automatic model_clock();
    int d, nx, ny, target;
    if (!resetn || !game_en) begin
      m_state = 0; m_x = 40; m_y = 60; m_head = 3; m_pend = 3;
      m_phase = 0; m_step = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_phase = 0; m_step = 0;
    end else if (m_state == 1) begin
      m_step = 0;
      if (crash_in) begin
        m_state = 2;
      end else begin
        target = m_pend;
        d = req_code(dir_req);
        if (d >= 0 && d != (m_head + 2) % 4) m_pend = d;
        m_phase++;
        if (m_phase == TICK) begin
          m_phase = 0;
          nx = m_x + dx(target);
          ny = m_y + dy(target);
`ifdef BIKE_WRAP_EN
          nx = (nx + XM + 1) % (XM + 1);
          ny = (ny + YM + 1) % (YM + 1);
`endif
          if (nx < 0 || nx > XM || ny < 0 || ny > YM) begin
            m_state = 2;
          end else begin
            m_x = nx; m_y = ny; m_head = target; m_step = 1;
          end
        end
      end
    end else begin
      m_step = 0;
    end
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    model_clock();
    #1;
    check("state",   int'(state),      m_state);
    check("x_pos",   int'(x_pos),      m_x);
    check("y_pos",   int'(y_pos),      m_y);
    check("heading", int'(heading),    m_head);
    check("step",    int'(step_pulse), m_step);
    check("alive",   int'(alive),      (m_state != 2) ? 1 : 0);
  endtask

  task automatic run_tick(input logic [3:0] d);
    dir_req = d;
    cycle();
    dir_req = 4'b0000;
    repeat (TICK - 1) cycle();
  endtask

  initial begin
    resetn = 1'b0; game_en = 1'b0; crash_in = 1'b0; dir_req = 4'b0000;
    cycle();
    cycle();
    check("rst_x", int'(x_pos), 40);
    check("rst_y", int'(y_pos), 60);
    check("rst_heading", int'(heading), 3);
    check("rst_state", int'(state), 0);
    check("rst_alive", int'(alive), 1);
    check("rst_step", int'(step_pulse), 0);
    check("rst_e_x", int'(e_x), 158);

    // Straight run: steps at cycles 5, 9, 13 after game_en.
    resetn = 1'b1; game_en = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      cycle();
      if (i == 5 || i == 9 || i == 13) begin
        check("run_step", int'(step_pulse), 1);
        check("run_x", int'(x_pos), 40 + (i - 1) / 4);
        check("run_y", int'(y_pos), 60);
        check("run_heading", int'(heading), 3);
      end else begin
        check("run_nostep", int'(step_pulse), 0);
      end
      if (i == 5) begin
        check("edge_x1", int'(e_x), 159);
        check("edge_step1", int'(e_step), 1);
      end
      if (i == 9) begin
        check("edge_x2", int'(e_x), E_X);
        check("edge_step2", int'(e_step), E_STEP);
        check("edge_alive", int'(e_alive), E_ALIVE);
        check("edge_state", int'(e_state), E_STATE);
      end
    end

    // Up then left inside one tick: left is the reverse of committed right.
    dir_req = 4'b1000; cycle();
    dir_req = 4'b0100; cycle();
    dir_req = 4'b0000; cycle(); cycle();
    check("turn_y", int'(y_pos), 59);
    check("turn_x", int'(x_pos), 43);
    check("turn_heading", int'(heading), 0);

    run_tick(4'b0001);
    check("right_x", int'(x_pos), 44);
    check("right_heading", int'(heading), 3);
    run_tick(4'b0100);
    check("rev_x", int'(x_pos), 45);
    check("rev_heading", int'(heading), 3);
    run_tick(4'b1010);
    check("multi_x", int'(x_pos), 46);
    check("multi_heading", int'(heading), 3);

    // crash_in coincident with the step cycle.
    repeat (TICK - 1) cycle();
    crash_in = 1'b1; cycle();
    crash_in = 1'b0;
    check("crash_state", int'(state), 2);
    check("crash_x", int'(x_pos), 46);
    check("crash_step", int'(step_pulse), 0);
    for (int i = 0; i < 8; i++) begin
      dir_req = 4'b1 << (i % 4);
      cycle();
    end
    dir_req = 4'b0000;
    check("frozen_x", int'(x_pos), 46);
    check("frozen_y", int'(y_pos), 59);
    game_en = 1'b0; cycle();
    check("idle_state", int'(state), 0);
    check("idle_x", int'(x_pos), 40);
    check("idle_y", int'(y_pos), 60);
    check("idle_heading", int'(heading), 3);

    // Reset in the middle of a run.
    game_en = 1'b1; cycle();
    repeat (5) run_tick(4'b0000);
    check("pre_rst_x", int'(x_pos), 45);
    resetn = 1'b0; cycle();
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_x", int'(x_pos), 40);
    check("mid_rst_step", int'(step_pulse), 0);
    resetn = 1'b1; game_en = 1'b0;
    repeat (5) cycle();
    check("hold_idle", int'(state), 0);

    // Drive straight up into the top edge.
    game_en = 1'b1; cycle();
    run_tick(4'b1000);
    repeat (65) run_tick(4'b0000);
    check("top_state", int'(state), UP_STATE);

    // Random traffic.
    game_en = 1'b0; cycle();
    for (int i = 0; i < 3000; i++) begin
      int r;
      resetn   = ($urandom % 500) != 0;
      game_en  = ($urandom % 200) != 0;
      crash_in = ($urandom % 300) == 0;
      r = $urandom % 8;
      if (r < 4)      dir_req = 4'b0000;
      else if (r < 7) dir_req = 4'b0001 << ($urandom % 4);
      else            dir_req = 4'($urandom % 16);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
